// File: rtl/approx_adder_pipe_pkg.sv
// Shared definitions for the segmented approximate adder pipeline:
// mode encoding and parameter legality check.
package approx_adder_pipe_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  function automatic bit params_legal(input int width, input int exact_lsb, input int apx_bits);
    return (exact_lsb >= 1) && (apx_bits >= 1) && (exact_lsb + apx_bits < width);
  endfunction

endpackage

// File: rtl/approx_seg_comb.sv
// Combinational segmented approximate sum: exact low segment, OR-approximated
// middle segment, carry-broken upper segment.
module approx_seg_comb #(
  parameter int WIDTH     = 16,
  parameter int EXACT_LSB = 6,
  parameter int APX_BITS  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int T  = EXACT_LSB + APX_BITS - 1;
  localparam int UW = WIDTH - EXACT_LSB - APX_BITS;

  logic [EXACT_LSB:0] lo;
  logic [UW:0]        up;
  logic               y;
  logic [APX_BITS-1:0] mid;

  assign lo  = {1'b0, a[EXACT_LSB-1:0]} + {1'b0, b[EXACT_LSB-1:0]} + {{EXACT_LSB{1'b0}}, cin};
  assign y   = (a[T] & b[T]) | (lo[EXACT_LSB] & (a[T] | b[T]));
  assign mid = (a[T:EXACT_LSB] ^ b[T:EXACT_LSB]) | {APX_BITS{y}};
  // The upper segment never sees a carry from below.
  assign up  = {1'b0, a[WIDTH-1:T+1]} + {1'b0, b[WIDTH-1:T+1]};
  assign sum = {up[UW-1:0], mid, lo[EXACT_LSB-1:0]};
  assign co  = up[UW];

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready pipelined adder with per-beat exact/approximate mode
// and a saturating counter of approximate results that differ from exact.
module approx_adder_pipe
  import approx_adder_pipe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EXACT_LSB = 6,
  parameter int APX_BITS  = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_mode,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int HW = WIDTH - EXACT_LSB;

  if (!params_legal(WIDTH, EXACT_LSB, APX_BITS)) begin : g_illegal
    $error("approx_adder_pipe: need EXACT_LSB>=1, APX_BITS>=1, EXACT_LSB+APX_BITS<WIDTH");
  end

  logic ready_en;
  logic stall;
  logic acc;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ready_en & ~stall;
  assign acc      = in_valid & in_ready;

  // Stage 1: operands plus the exact low segment, shared by both modes.
  logic                 v1;
  logic [WIDTH-1:0]     a1;
  logic [WIDTH-1:0]     b1;
  logic                 cin1;
  logic                 mode1;
  logic [EXACT_LSB-1:0] lo1;
  logic                 clo1;
  logic [EXACT_LSB:0]   lo_s0;

  assign lo_s0 = {1'b0, in_a[EXACT_LSB-1:0]} + {1'b0, in_b[EXACT_LSB-1:0]}
               + {{EXACT_LSB{1'b0}}, in_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      v1       <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      cin1     <= 1'b0;
      mode1    <= MODE_EXACT;
      lo1      <= '0;
      clo1     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (!stall) begin
        v1 <= acc;
        if (acc) begin
          a1    <= in_a;
          b1    <= in_b;
          cin1  <= in_cin;
          mode1 <= in_mode;
          lo1   <= lo_s0[EXACT_LSB-1:0];
          clo1  <= lo_s0[EXACT_LSB];
        end
      end
    end
  end

  // Stage 2: finish the exact carry chain from the stage-1 low carry.
  logic [WIDTH-1:0] apx_sum;
  logic             apx_co;
  logic [HW:0]      hi2;
  logic [WIDTH:0]   exact2;
  logic [WIDTH:0]   ref2;

  approx_seg_comb #(
    .WIDTH    (WIDTH),
    .EXACT_LSB(EXACT_LSB),
    .APX_BITS (APX_BITS)
  ) u_seg (
    .a  (a1),
    .b  (b1),
    .cin(cin1),
    .sum(apx_sum),
    .co (apx_co)
  );

  assign hi2    = {1'b0, a1[WIDTH-1:EXACT_LSB]} + {1'b0, b1[WIDTH-1:EXACT_LSB]}
                + {{HW{1'b0}}, clo1};
  assign exact2 = {hi2, lo1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_co    <= 1'b0;
      out_mode  <= MODE_EXACT;
      ref2      <= '0;
    end else if (!stall) begin
      out_valid <= v1;
      if (v1) begin
        out_sum  <= (mode1 == MODE_APPROX) ? apx_sum : exact2[WIDTH-1:0];
        out_co   <= (mode1 == MODE_APPROX) ? apx_co  : exact2[WIDTH];
        out_mode <= mode1;
        ref2     <= exact2;
      end
    end
  end

  logic mism;
  assign mism = (out_mode == MODE_APPROX) && ({out_co, out_sum} != ref2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && mism && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Scoreboard bench for approx_adder_pipe (default segments, 2-bit error counter).
module tb_approx_adder_pipe;

  localparam int W     = 16;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_cin;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_co;
  logic             out_mode;
  logic             err_clr;
  logic [CNT_W-1:0] err_cnt;

  approx_adder_pipe #(
    .WIDTH(W), .EXACT_LSB(6), .APX_BITS(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co), .out_mode(out_mode),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         mode;
    logic [W:0]   ex;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_exp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: default segments L=[5:0], M=[9:6], U=[15:10].
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic mode);
    exp_t e;
    logic [6:0] lo;
    logic [6:0] up;
    logic       y;
    logic [3:0] mid;
    e.ex = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.mode = mode;
    if (mode) begin
      lo  = {1'b0, a[5:0]} + {1'b0, b[5:0]} + {6'd0, cin};
      y   = (a[9] & b[9]) | (lo[6] & (a[9] | b[9]));
      mid = (a[9:6] ^ b[9:6]) | {4{y}};
      up  = {1'b0, a[15:10]} + {1'b0, b[15:10]};
      e.sum = {up[5:0], mid, lo[5:0]};
      e.co  = up[6];
    end else begin
      e.sum = e.ex[W-1:0];
      e.co  = e.ex[W];
    end
    return e;
  endfunction

  // One clock: evaluate handshakes from the current inputs, then cross the edge.
  task automatic step(output bit acc);
    bit   cons;
    bit   mism;
    exp_t e;
    #1;
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
    mism = 1'b0;
    if (out_valid && !out_ready) begin
      chk("stall_rdy", in_ready, 0);
      if (sb.size() > 0) chk("hold_sum", out_sum, sb[0].sum);
    end
    if (cons) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sum", out_sum, e.sum);
        chk("co", out_co, e.co);
        chk("mode", out_mode, e.mode);
        mism = e.mode && ({e.co, e.sum} != e.ex);
      end
    end
    if (err_clr) err_exp = 0;
    else if (cons && mism && err_exp != (1 << CNT_W) - 1) err_exp++;
    if (acc) sb.push_back(model(in_a, in_b, in_cin, in_mode));
    @(posedge clk);
    #1;
    chk("err_cnt", err_cnt, err_exp);
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic mode);
    bit acc;
    in_a = a; in_b = b; in_cin = cin; in_mode = mode; in_valid = 1'b1;
    step(acc);
    chk("accept", acc, 1);
    in_valid = 1'b0;
    chk("lat_edge1", out_valid, 0);
    step(acc);
    chk("lat_edge2", out_valid, 1);
    step(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int sent;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_mode = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_co", out_co, 0);
    chk("rst_mode", out_mode, 0);
    chk("rst_err", err_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", in_ready, 1);

    beat(16'd8, 16'd15, 1'b0, 1'b0);
    beat(16'd8, 16'd15, 1'b0, 1'b1);
    beat(16'd11, 16'd31, 1'b0, 1'b0);
    beat(16'd11, 16'd31, 1'b0, 1'b1);
    beat(16'h003F, 16'h0001, 1'b0, 1'b1);
    beat(16'h003F, 16'h0001, 1'b0, 1'b0);
    beat(16'h0200, 16'h0200, 1'b0, 1'b1);
    beat(16'hFC00, 16'h0400, 1'b0, 1'b1);
    beat(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    beat(16'hFFFF, 16'h0000, 1'b1, 1'b1);

    // Back-to-back stream with a 3-cycle output stall.
    sent = 0;
    for (int k = 0; k < 60; k++) begin
      if (sent >= 8 && sb.size() == 0) break;
      out_ready = !(k >= 3 && k <= 5);
      in_valid  = (sent < 8);
      in_a      = 16'(16'h1357 * (sent + 1));
      in_b      = 16'(16'h0F0F ^ (sent * 37));
      in_cin    = sent[1];
      in_mode   = sent[0];
      step(acc);
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_sent", sent, 8);
    chk("stream_left", sb.size(), 0);

    // Saturation of the 2-bit counter.
    err_clr = 1'b1;
    step(acc);
    err_clr = 1'b0;
    sent = 0;
    for (int k = 0; k < 30; k++) begin
      if (sent >= 5 && sb.size() == 0) break;
      in_valid = (sent < 5);
      in_a = 16'h0200; in_b = 16'h0200; in_cin = 1'b0; in_mode = 1'b1;
      step(acc);
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("sat_cnt", err_cnt, 3);

    // Clear wins over a same-cycle increment.
    in_a = 16'h003F; in_b = 16'h0001; in_cin = 1'b0; in_mode = 1'b1; in_valid = 1'b1;
    step(acc);
    in_valid = 1'b0;
    step(acc);
    err_clr = 1'b1;
    step(acc);
    err_clr = 1'b0;
    chk("clr_prio", err_cnt, 0);

    // Reset mid-stream.
    in_a = 16'h0200; in_b = 16'h0200; in_cin = 1'b0; in_mode = 1'b1; in_valid = 1'b1;
    repeat (4) step(acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_err", err_cnt, 0);
    sb.delete();
    err_exp = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst2", in_ready, 1);
    beat(16'd100, 16'd27, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
